wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_if.sv | 22 ++
 rtl/wb_port_arbiter.sv | 65 ++++++
 tb/tb_wb_port_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: pipeline/MDU write requests in, register-file write port and stall out.
interface wb_port_arbiter_if;
  logic        Pipe_RegWrite;
  logic [4:0]  Pipe_WriteReg;
  logic [31:0] Pipe_Data;
  logic        MDU_Valid;
  logic [4:0]  MDU_WriteReg;
  logic [31:0] MDU_Data;
  logic        MDU_Ready;
  logic        RF_RegWrite;
  logic [4:0]  RF_WriteReg;
  logic [31:0] RF_WriteData;
  logic        Stall_Out;
  modport master (
    output Pipe_RegWrite, Pipe_WriteReg, Pipe_Data, MDU_Valid, MDU_WriteReg, MDU_Data,
    input  MDU_Ready, RF_RegWrite, RF_WriteReg, RF_WriteData, Stall_Out
  );
  modport slave (
    input  Pipe_RegWrite, Pipe_WriteReg, Pipe_Data, MDU_Valid, MDU_WriteReg, MDU_Data,
    output MDU_Ready, RF_RegWrite, RF_WriteReg, RF_WriteData, Stall_Out
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between WB and a buffered MDU with starvation forcing.
// Optional WB_ARB_BYPASS_EN lets an MDU result skip the empty FIFO when the port is idle.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic Clk,
  input logic Reset,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FORCE = 1'b1;
  logic [0:0]    state;
  logic [36:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] starve, starve_nxt;
  logic          full, empty, pipe_gnt, head_gnt, byp_gnt, push, to_force;
  logic [4:0]    gnt_reg;
  logic [31:0]   gnt_data;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign bus.MDU_Ready = !full;
  assign pipe_gnt = state == IDLE && bus.Pipe_RegWrite;
  assign head_gnt = !empty && (state == FORCE || !bus.Pipe_RegWrite);
`ifdef WB_ARB_BYPASS_EN
  assign byp_gnt = state == IDLE && !bus.Pipe_RegWrite && empty && bus.MDU_Valid;
`else
  assign byp_gnt = 1'b0;
`endif
  assign push = bus.MDU_Valid && !full && !byp_gnt;
  always_comb begin
    gnt_reg    = pipe_gnt ? bus.Pipe_WriteReg : head_gnt ? mem[rd_ptr][36:32] : bus.MDU_WriteReg;
    gnt_data   = pipe_gnt ? bus.Pipe_Data : head_gnt ? mem[rd_ptr][31:0] : bus.MDU_Data;
    starve_nxt = (head_gnt || empty) ? '0 : (starve == CW'(STARVE_LIMIT)) ? starve : starve + 1'b1;
    to_force   = state == IDLE && starve_nxt == CW'(STARVE_LIMIT);
  end
  // Storage carries no reset: entries are only visible through count.
  always_ff @(posedge Clk)
    if (push) mem[wr_ptr] <= {bus.MDU_WriteReg, bus.MDU_Data};
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state            <= IDLE;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      starve           <= '0;
      bus.RF_RegWrite  <= 1'b0;
      bus.RF_WriteReg  <= '0;
      bus.RF_WriteData <= '0;
      bus.Stall_Out    <= 1'b0;
    end else begin
      state            <= to_force ? FORCE : IDLE;
      bus.Stall_Out    <= to_force;
      starve           <= starve_nxt;
      rd_ptr           <= rd_ptr + AW'(head_gnt);
      wr_ptr           <= wr_ptr + AW'(push);
      count            <= count + (AW+1)'(push) - (AW+1)'(head_gnt);
      bus.RF_RegWrite  <= (pipe_gnt || head_gnt || byp_gnt) && gnt_reg != '0;
      bus.RF_WriteReg  <= gnt_reg;
      bus.RF_WriteData <= gnt_data;
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed steps with a scoreboard of expected register-file writes.
module tb_wb_port_arbiter;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int ncmp = 0;
  int nfail = 0;
  logic [36:0] exp_q [$];
  wb_port_arbiter_if bus();
  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock edge, then any RF write is matched against the scoreboard head.
  task automatic step();
    logic [36:0] e;
    @(posedge Clk);
    #1;
    if (bus.RF_RegWrite === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", {bus.RF_WriteReg, bus.RF_WriteData}, 37'h1F_FFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("rf_write", {bus.RF_WriteReg, bus.RF_WriteData}, e);
      end
    end
  endtask

  task automatic pipe(input logic we, input logic [4:0] r, input logic [31:0] d);
    bus.Pipe_RegWrite = we;
    bus.Pipe_WriteReg = r;
    bus.Pipe_Data = d;
  endtask

  task automatic mdu(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.MDU_Valid = v;
    bus.MDU_WriteReg = r;
    bus.MDU_Data = d;
  endtask

  initial begin
    pipe(0, 0, 0);
    mdu(0, 0, 0);
    #1 Reset = 1'b1;
    #2;
    chk("rst_we", 37'(bus.RF_RegWrite), 37'd0);
    chk("rst_reg_data", {bus.RF_WriteReg, bus.RF_WriteData}, 37'd0);
    chk("rst_stall", 37'(bus.Stall_Out), 37'd0);
    chk("rst_ready", 37'(bus.MDU_Ready), 37'd1);
    @(posedge Clk);
    @(posedge Clk);
    #3 Reset = 1'b0;
    // pipeline write to reg 5
    pipe(1, 5, 32'h1234);
    exp_q.push_back({5'd5, 32'h1234});
    step();
    chk("pipe_we", 37'(bus.RF_RegWrite), 37'd1);
    pipe(0, 0, 0);
    step();
    chk("idle_we", 37'(bus.RF_RegWrite), 37'd0);
    // pipeline write to reg 0 is dropped
    pipe(1, 0, 32'h77);
    step();
    chk("reg0_we", 37'(bus.RF_RegWrite), 37'd0);
    pipe(0, 0, 0);
    // MDU result with pipe idle
    mdu(1, 9, 32'hCAFE);
    exp_q.push_back({5'd9, 32'hCAFE});
    step();
    mdu(0, 0, 0);
`ifdef WB_ARB_BYPASS_EN
    chk("mdu_lat1_we", 37'(bus.RF_RegWrite), 37'd1);
    step();
    chk("mdu_after_we", 37'(bus.RF_RegWrite), 37'd0);
`else
    chk("mdu_lat1_we", 37'(bus.RF_RegWrite), 37'd0);
    step();
    chk("mdu_lat2_we", 37'(bus.RF_RegWrite), 37'd1);
`endif
    step();
    chk("mdu_drained_we", 37'(bus.RF_RegWrite), 37'd0);
    // starvation: one buffered entry behind a continuous pipeline write
    pipe(1, 3, 32'h33);
    mdu(1, 10, 32'hA0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({5'd3, 32'h33});
      step();
      mdu(0, 0, 0);
      chk($sformatf("starve_stall%0d", i), 37'(bus.Stall_Out), 37'(i == 4));
    end
    exp_q.push_back({5'd10, 32'hA0});
    step();
    chk("force_we", 37'(bus.RF_RegWrite), 37'd1);
    chk("force_stall_clr", 37'(bus.Stall_Out), 37'd0);
    pipe(0, 0, 0);
    step();
    chk("post_force_we", 37'(bus.RF_RegWrite), 37'd0);
    // FIFO full: third MDU result held until a pop
    pipe(1, 4, 32'h44);
    mdu(1, 11, 32'hB1);
    exp_q.push_back({5'd4, 32'h44});
    step();
    mdu(1, 12, 32'hB2);
    exp_q.push_back({5'd4, 32'h44});
    step();
    chk("full_ready", 37'(bus.MDU_Ready), 37'd0);
    mdu(1, 13, 32'hB3);
    exp_q.push_back({5'd4, 32'h44});
    step();
    chk("held_ready", 37'(bus.MDU_Ready), 37'd0);
    pipe(0, 0, 0);
    exp_q.push_back({5'd11, 32'hB1});
    step();
    chk("pop_ready", 37'(bus.MDU_Ready), 37'd1);
    exp_q.push_back({5'd12, 32'hB2});
    step();
    mdu(0, 0, 0);
    exp_q.push_back({5'd13, 32'hB3});
    step();
    chk("third_we", 37'(bus.RF_RegWrite), 37'd1);
    step();
    chk("drain_we", 37'(bus.RF_RegWrite), 37'd0);
    chk("drain_ready", 37'(bus.MDU_Ready), 37'd1);
    // reset during FORCE with two buffered entries
    pipe(1, 6, 32'h66);
    mdu(1, 20, 32'hD0);
    exp_q.push_back({5'd6, 32'h66});
    step();
    mdu(1, 21, 32'hD1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({5'd6, 32'h66});
      step();
      mdu(0, 0, 0);
    end
    chk("pre_rst_stall", 37'(bus.Stall_Out), 37'd1);
    chk("pre_rst_ready", 37'(bus.MDU_Ready), 37'd0);
    #2 Reset = 1'b1;
    #1;
    chk("arst_we", 37'(bus.RF_RegWrite), 37'd0);
    chk("arst_reg_data", {bus.RF_WriteReg, bus.RF_WriteData}, 37'd0);
    chk("arst_stall", 37'(bus.Stall_Out), 37'd0);
    chk("arst_ready", 37'(bus.MDU_Ready), 37'd1);
    pipe(0, 0, 0);
    Reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("post_rst_we%0d", i), 37'(bus.RF_RegWrite), 37'd0);
    end
    chk("scoreboard_empty", 37'(exp_q.size()), 37'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
